// File: rtl/uart_pkg.sv
// Shared types, frame constants and baud divider helper for the UART
// transmitter with its byte FIFO.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // start + 8 data + stop
    localparam int FRAME_BITS = 10;

    function automatic int calc_div(input int clk_freq, input int baudrate);
        return clk_freq / baudrate;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Show-ahead byte FIFO: head byte is always visible on data_o, flush wins
// over push, and occupancy is held in a registered level counter.
module uart_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [7:0]               data_i,
    input  logic                     pop_i,
    output logic [7:0]               data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Status flags come from the registered level only, so a same-cycle pop
    // never opens the input while the FIFO is full.
    always_comb begin
        full_o    = (level_r == LW'(DEPTH));
        empty_o   = (level_r == {LW{1'b0}});
        do_push_s = push_i & ~full_o & ~flush_i;
        do_pop_s  = pop_i & ~empty_o;
    end

    assign data_o  = mem_r[rd_ptr_r];
    assign level_o = level_r;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else if (flush_i) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Storage array; contents are qualified by the level, so no reset needed.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from a byte FIFO. The serializer pops the head
// byte on entering START and sends frames back-to-back while bytes remain.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUDRATE   = 1000000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic                          flush_i,
    output logic                          txd_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int              DIV      = calc_div(CLK_FREQ, BAUDRATE);
    localparam int              CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DIV - 1);
    localparam logic [2:0]      LAST_BIT = 3'(FRAME_BITS - 3);
    localparam int              LW       = $clog2(FIFO_DEPTH) + 1;

    uart_state_t   state_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          txd_r;

    logic [7:0]    head_s;
    logic [LW-1:0] level_s;
    logic          full_s;
    logic          empty_s;
    logic          pop_s;
    logic          bit_end_s;

    uart_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (valid_i),
        .data_i  (data_i),
        .pop_i   (pop_s),
        .data_o  (head_s),
        .level_o (level_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // Pop on leaving IDLE or at the end of a stop bit when more bytes wait.
    always_comb begin
        bit_end_s = (cnt_r == CNT_LAST);
        pop_s     = 1'b0;
        case (state_r)
            IDLE:    pop_s = ~empty_s;
            STOP:    pop_s = bit_end_s & ~empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // Serializer; txd_r is registered from the current state, so the line
    // trails the state by one cycle and every bit still lasts DIV cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            txd_r     <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    txd_r <= 1'b1;
                    cnt_r <= {CW{1'b0}};
                    if (pop_s) begin
                        shift_r <= head_s;
                        state_r <= START;
                    end
                end
                START: begin
                    txd_r <= 1'b0;
                    if (bit_end_s) begin
                        cnt_r     <= {CW{1'b0}};
                        bit_idx_r <= 3'd0;
                        state_r   <= DATA;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DATA: begin
                    txd_r <= shift_r[bit_idx_r];
                    if (bit_end_s) begin
                        cnt_r     <= {CW{1'b0}};
                        bit_idx_r <= bit_idx_r + 3'd1;
                        if (bit_idx_r == LAST_BIT) begin
                            state_r <= STOP;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                STOP: begin
                    txd_r <= 1'b1;
                    if (bit_end_s) begin
                        cnt_r <= {CW{1'b0}};
                        if (pop_s) begin
                            shift_r <= head_s;
                            state_r <= START;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    txd_r   <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign txd_o   = txd_r;
    assign ready_o = ~full_s;
    assign level_o = level_s;
    assign busy_o  = (state_r != IDLE) | (level_s != {LW{1'b0}});

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50000000, giving the clk_i frequency in Hz.
REQ-002 The block SHALL have parameter BAUDRATE, default 1000000, giving the line rate in bit/s.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16, giving the byte FIFO depth; it SHALL be a power of two, 2..256.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port data_i, input, 8 bits: the byte to transmit.
REQ-007 The block SHALL have port valid_i, input, 1 bit: data_i is valid.
REQ-008 The block SHALL have port ready_o, output, 1 bit: the FIFO can accept a byte.
REQ-009 The block SHALL have port flush_i, input, 1 bit: discard all queued bytes.
REQ-010 The block SHALL have port txd_o, output, 1 bit: serial line, idle high, registered.
REQ-011 The block SHALL have port busy_o, output, 1 bit: a frame is in progress or the FIFO is non-empty.
REQ-012 The block SHALL have port level_o, output, clog2(FIFO_DEPTH)+1 bits: FIFO occupancy.

Function
REQ-013 The block SHALL accept a byte on every rising edge where valid_i and ready_o are both 1.
REQ-014 ready_o SHALL equal NOT full, derived from registered occupancy only. A pop in the same cycle SHALL NOT make ready_o high while full.
REQ-015 On a simultaneous push and pop with the FIFO not full, both SHALL occur and level_o SHALL be unchanged.
REQ-016 Bit period SHALL be DIV = CLK_FREQ/BAUDRATE cycles (integer divide); defaults give 50.
REQ-017 Frame format SHALL be 8N1: start bit 0, data bits LSB first, one stop bit 1, each lasting exactly DIV cycles.
REQ-018 The serializer FSM SHALL have four states:
- IDLE: txd_o=1. Go to START when the FIFO is non-empty, popping the head byte.
- START: txd_o=0 for DIV cycles, then DATA.
- DATA: 8 bits, a 3-bit index that wraps 7->0 into STOP.
- STOP: txd_o=1 for DIV cycles, then START if the FIFO is non-empty (pop), else IDLE.
REQ-019 Latency: a byte accepted into an empty FIFO with the FSM in IDLE SHALL drive txd_o low on the second rising edge after the accepting edge.
REQ-020 Back-to-back bytes SHALL be sent with no idle gap: each frame is exactly 10*DIV cycles.
REQ-021 flush_i=1 SHALL zero level_o on the next edge and ignore any simultaneous push. A frame in progress SHALL complete unaltered.
REQ-022 busy_o SHALL be 0 only when the FSM is in IDLE and level_o=0.
REQ-023 Read and write pointers SHALL wrap modulo FIFO_DEPTH. level_o SHALL saturate neither below 0 nor above FIFO_DEPTH.

Reset
REQ-024 rst_ni=0 SHALL, asynchronously, force:
- txd_o=1, busy_o=0, level_o=0;
- ready_o=1 once released;
- the FSM to IDLE and the bit counters to 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately (line high), and no byte SHALL be sent after release until a new push.

Structure
REQ-026 A shared package uart_pkg SHALL hold:
- the FSM state enum (IDLE, START, DATA, STOP);
- the frame length constant 10;
- the function computing DIV from CLK_FREQ and BAUDRATE.
REQ-027 The FIFO SHALL be a sub-module uart_fifo: synchronous, single clock, show-ahead, with push/pop/flush/level. The FSM and baud counter SHALL live in uart_tx_fifo.

Verification
REQ-028 Reset, then push 0x55 into the idle block. Required: txd_o low 2 edges later, then pattern 0,1,0,1,0,1,0,1,0,1 in 50-cycle bits, then busy_o=0 at cycle 500 after the start edge.
REQ-029 Push 0xA5, 0x3C, 0xFF back-to-back. Required: three frames in exactly 1500 cycles with no idle gap, and the data decoded LSB first matches.
REQ-030 Push 17 bytes with valid_i held high while one frame is active. Required: ready_o=0 at level_o=16, the 17th byte held until a pop, and all 17 bytes transmitted in order.
REQ-031 Push 5 bytes, then pulse flush_i during bit 3 of the first frame. Required: the first frame completes, level_o=0, and the line idles high afterwards.
REQ-032 Assert rst_ni=0 mid-DATA of 0x00. Required: txd_o=1 in the same cycle, level_o=0, and no frame after release.
REQ-033 With FIFO full, apply push and pop in the same cycle. Required: the push is not accepted, and level_o goes from 16 to 15.
